ip_switch_ctrl: RTL



---
 rtl/ecos_ipsel_pkg.sv | 13 +
 rtl/ipsel_sync_debounce.sv | 41 ++++
 rtl/ip_switch_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/ecos_ipsel_pkg.sv
// ecos_ipsel_pkg: shared state encoding, default sizing and select-code validity check for the IP switch controller
package ecos_ipsel_pkg;
  localparam int NUM_IP_DEF = 6;
  localparam int SEL_W_DEF = 3;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STABLE_CYCLES_DEF = 16;
  localparam int DRAIN_CYCLES_DEF = 64;
  localparam int RST_HOLD_CYCLES_DEF = 32;
  typedef enum logic [2:0] {ST_INIT, ST_HOLD, ST_RUN, ST_DRAIN, ST_ISOLATE} ipsel_state_e;
  function automatic logic is_valid_sel(input int code, input int num_ip);
    return code < num_ip;
  endfunction
endpackage

// File: rtl/ipsel_sync_debounce.sv
// ipsel_sync_debounce: synchronises the async ip_sel pad code and accepts it once it holds steady
module ipsel_sync_debounce import ecos_ipsel_pkg::*; #(
  parameter int SEL_W = SEL_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SEL_W-1:0] stable_o,
  output logic             stable_vld_o,
  output logic             stable_stb_o
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  logic [SEL_W-1:0] sync_q [SYNC_STAGES];
  logic [SEL_W-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic same, accept;
  assign same = sync_q[SYNC_STAGES-1] == prev_q;
  // acceptance coincides with the counter reaching its terminal value, which then saturates
  assign accept = same && cnt_q == CNT_W'(STABLE_CYCLES-2);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      cnt_q <= '0;
      stable_o <= '0;
      stable_vld_o <= 1'b0;
      stable_stb_o <= 1'b0;
    end else begin
      sync_q[0] <= sel_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q <= !same ? '0 : cnt_q == CNT_W'(STABLE_CYCLES-1) ? cnt_q : cnt_q + 1'b1;
      stable_stb_o <= accept;
      if (accept) begin
        stable_o <= sync_q[SYNC_STAGES-1];
        stable_vld_o <= 1'b1;
      end
    end
endmodule

// File: rtl/ip_switch_ctrl.sv
// ip_switch_ctrl: drains the active hard IP, isolates all IPs, re-points the pad mux and releases the selected IP
module ip_switch_ctrl import ecos_ipsel_pkg::*; #(
  parameter int NUM_IP = NUM_IP_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [SEL_W-1:0]  ip_sel_i,
  input  logic [NUM_IP-1:0] ip_idle_i,
  output logic [NUM_IP-1:0] ip_rst_n_o,
  output logic [SEL_W-1:0]  pad_sel_o,
  output logic              pad_sel_vld_o,
  output logic              switch_busy_o,
  output logic              sel_err_o,
  output logic              drain_timeout_o
);
  localparam int MAX_C = DRAIN_CYCLES > RST_HOLD_CYCLES ? DRAIN_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_W = $clog2(MAX_C);
  ipsel_state_e state_q, state_n;
  logic [SEL_W-1:0] tgt_q, tgt_n, nxt_q, nxt_n, stable;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic stable_vld, stable_stb, valid, idle, err_n, to_n, act_n;
  ipsel_sync_debounce #(
    .SEL_W(SEL_W),
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .sel_i(ip_sel_i),
    .stable_o(stable),
    .stable_vld_o(stable_vld),
    .stable_stb_o(stable_stb)
  );
  assign valid = is_valid_sel(32'(stable), NUM_IP);
  assign idle = ip_idle_i[tgt_q];
  assign act_n = state_n == ST_RUN || state_n == ST_DRAIN;
  always_comb begin
    state_n = state_q;
    tgt_n = tgt_q;
    nxt_n = nxt_q;
    cnt_n = cnt_q + 1'b1;
    err_n = 1'b0;
    to_n = 1'b0;
    case (state_q)
      ST_INIT:
        if (stable_stb) begin
          if (valid) begin
            state_n = ST_HOLD;
            tgt_n = stable;
            cnt_n = '0;
          end else err_n = 1'b1;
        end
      ST_HOLD: state_n = cnt_q == CNT_W'(RST_HOLD_CYCLES-1) ? ST_RUN : ST_HOLD;
      // level compare so a code that settled during a switch is picked up on return
      ST_RUN:
        if (stable_vld && stable != tgt_q) begin
          if (valid) begin
            state_n = ST_DRAIN;
            nxt_n = stable;
            cnt_n = '0;
          end else err_n = stable_stb;
        end
      ST_DRAIN:
        if (idle || cnt_q == CNT_W'(DRAIN_CYCLES-1)) begin
          state_n = ST_ISOLATE;
          to_n = !idle;
        end
      ST_ISOLATE: begin
        state_n = ST_HOLD;
        tgt_n = nxt_q;
        cnt_n = '0;
      end
      default: state_n = ST_INIT;
    endcase
  end
  // outputs are registered from next-state values so they stay aligned with the state and glitch-free
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      tgt_q <= '0;
      nxt_q <= '0;
      cnt_q <= '0;
      ip_rst_n_o <= '0;
      pad_sel_o <= '0;
      pad_sel_vld_o <= 1'b0;
      switch_busy_o <= 1'b1;
      sel_err_o <= 1'b0;
      drain_timeout_o <= 1'b0;
    end else begin
      state_q <= state_n;
      tgt_q <= tgt_n;
      nxt_q <= nxt_n;
      cnt_q <= cnt_n;
      ip_rst_n_o <= act_n ? NUM_IP'(1) << tgt_n : '0;
      pad_sel_o <= tgt_n;
      pad_sel_vld_o <= act_n;
      switch_busy_o <= state_n != ST_RUN;
      sel_err_o <= err_n;
      drain_timeout_o <= to_n;
    end
endmodule
